// File: rtl/platform_ocm_copy_master.sv
// rtl/platform_ocm_copy_master.sv - Avalon-MM block COPY/FILL master for one on-chip memory port
// Optional write-data checksum accumulator: define PLATFORM_OCM_COPY_CHECKSUM_EN.

module platform_ocm_copy_master #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int BE_W   = DATA_W / 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_fill_data,
  input  logic [BE_W-1:0]   cmd_fill_be,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              avm_clken
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] fill_data;
  logic [BE_W-1:0]   fill_be;
  logic              mode;
  logic              abort_q;
  logic              clken_q;
  logic              start_ok;
  logic              abort_hit;
  logic              wr_issue;

  // Start is only honoured in IDLE and loses to a simultaneous abort.
  assign start_ok  = (state == S_IDLE) && cmd_start && !cmd_abort;
  assign abort_hit = cmd_abort && ((state == S_RD) || (state == S_CAP) || (state == S_WR));
  assign wr_issue  = (state == S_WR) && !cmd_abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (cmd_len == '0) begin
            state_nxt = S_FIN;
          end else if (cmd_mode) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD:  state_nxt = cmd_abort ? S_FIN : S_CAP;
      S_CAP: state_nxt = cmd_abort ? S_FIN : S_WR;
      S_WR: begin
        if (cmd_abort || (remaining == LEN_W'(1))) begin
          state_nxt = S_FIN;
        end else if (mode) begin
          state_nxt = S_WR;
        end else begin
          state_nxt = S_RD;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // An abort suppresses the access in the very cycle it is seen.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    busy           = (state != S_IDLE);
    done           = (state == S_FIN);
    aborted        = (state == S_FIN) && abort_q;
    case (state)
      S_RD: begin
        if (!cmd_abort) begin
          avm_chipselect = 1'b1;
          avm_address    = src_ptr;
          avm_byteenable = '1;
        end
      end
      S_WR: begin
        if (!cmd_abort) begin
          avm_chipselect = 1'b1;
          avm_write      = 1'b1;
          avm_address    = dst_ptr;
          avm_byteenable = mode ? fill_be : '1;
          avm_writedata  = mode ? fill_data : rd_buf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      rd_buf    <= '0;
      fill_data <= '0;
      fill_be   <= '0;
      mode      <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        src_ptr   <= cmd_src;
        dst_ptr   <= cmd_dst;
        remaining <= cmd_len;
        mode      <= cmd_mode;
        fill_data <= cmd_fill_data;
        fill_be   <= cmd_fill_be;
        abort_q   <= 1'b0;
      end
      if (abort_hit) begin
        abort_q <= 1'b1;
      end
      if ((state == S_CAP) && !cmd_abort) begin
        rd_buf <= avm_readdata;
      end
      if (wr_issue) begin
        remaining <= remaining - LEN_W'(1);
        src_ptr   <= src_ptr + ADDR_W'(1);
        dst_ptr   <= dst_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken_q <= 1'b0;
    end else begin
      clken_q <= 1'b1;
    end
  end
  assign avm_clken = clken_q;

`ifdef PLATFORM_OCM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] wr_mask;

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      wr_mask[i*8 +: 8] = {8{avm_byteenable[i]}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (wr_issue) begin
      csum_q <= csum_q ^ (avm_writedata & wr_mask);
    end
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_platform_ocm_copy_master.sv
// tb/tb_platform_ocm_copy_master.sv - scoreboard bench for platform_ocm_copy_master
// Checksum expectations follow PLATFORM_OCM_COPY_CHECKSUM_EN.

module tb_platform_ocm_copy_master;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_mode = 1'b0;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_fill_data = '0;
  logic [BE_W-1:0]   cmd_fill_be = '0;
  logic              cmd_abort = 1'b0;
  logic              busy, done, aborted, avm_chipselect, avm_write, avm_clken;
  logic [DATA_W-1:0] checksum, avm_writedata;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic [ADDR_W-1:0] avm_address;
  logic [BE_W-1:0]   avm_byteenable;

  always #5 clk = ~clk;

  platform_ocm_copy_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .cmd_fill_data(cmd_fill_data), .cmd_fill_be(cmd_fill_be),
    .cmd_abort(cmd_abort), .busy(busy), .done(done), .aborted(aborted), .checksum(checksum),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_clken(avm_clken)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_t;

  wr_t               wq[$];
  logic [ADDR_W-1:0] rq[$];
  logic [DATA_W-1:0] mem [0:511];
  logic [DATA_W-1:0] ref_mem [0:511];
  logic [DATA_W-1:0] exp_cs;
  logic              init_mem = 1'b1;
  int                vectors = 0;
  int                miscompares = 0;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    if (i < 3) return 64'(i + 1);
    return 64'hBEEF_0000_0000_0000 | (64'(i) << 32) | 64'(i * 3 + 5);
  endfunction

  function automatic logic [DATA_W-1:0] bmask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BE_W; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Slave model: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    end else if (avm_chipselect) begin
      if (avm_write) begin
        for (int b = 0; b < BE_W; b++)
          if (avm_byteenable[b]) mem[avm_address][b*8 +: 8] <= avm_writedata[b*8 +: 8];
      end else begin
        avm_readdata <= mem[avm_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && avm_chipselect) begin
      if (avm_write) begin
        vectors++;
        assert (wq.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_write observed addr=%h expected no write", avm_address);
        end
        if (wq.size() > 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 64'(avm_address), 64'(w.addr));
          chk("wr_data", avm_writedata, w.data);
          chk("wr_be", 64'(avm_byteenable), 64'(w.be));
        end
      end else begin
        vectors++;
        assert (rq.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_read observed addr=%h expected no read", avm_address);
        end
        if (rq.size() > 0) chk("rd_addr", 64'(avm_address), 64'(rq.pop_front()));
      end
    end
  end

  task automatic exp_fill(input logic [ADDR_W-1:0] dst, input int n, input logic [DATA_W-1:0] d,
                          input logic [BE_W-1:0] be);
    wr_t w;
    logic [ADDR_W-1:0] a;
    exp_cs = '0;
    for (int i = 0; i < n; i++) begin
      a = dst + ADDR_W'(i);
      w.addr = a; w.data = d; w.be = be;
      wq.push_back(w);
      ref_mem[a] = (ref_mem[a] & ~bmask(be)) | (d & bmask(be));
      exp_cs ^= d & bmask(be);
    end
  endtask

  task automatic exp_copy(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst, input int n);
    wr_t w;
    logic [ADDR_W-1:0] s, a;
    exp_cs = '0;
    for (int i = 0; i < n; i++) begin
      s = src + ADDR_W'(i);
      a = dst + ADDR_W'(i);
      rq.push_back(s);
      w.addr = a; w.data = ref_mem[s]; w.be = '1;
      wq.push_back(w);
      ref_mem[a] = w.data;
      exp_cs ^= w.data;
    end
  endtask

  task automatic issue(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                       input logic [LEN_W-1:0] n, input logic [DATA_W-1:0] fd, input logic [BE_W-1:0] fb);
    @(posedge clk); #1;
    cmd_mode = m; cmd_src = s; cmd_dst = d; cmd_len = n; cmd_fill_data = fd; cmd_fill_be = fb;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] cs_exp();
`ifdef PLATFORM_OCM_COPY_CHECKSUM_EN
    return exp_cs;
`else
    return '0;
`endif
  endfunction

  task automatic wait_done(input string tag, input int exp_lat, input logic exp_ab);
    int lat;
    logic seen;
    lat = 1;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      lat++;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_aborted"}, 64'(aborted), 64'(exp_ab));
    chk({tag, "_wq_empty"}, 64'(wq.size()), 64'(0));
    chk({tag, "_rq_empty"}, 64'(rq.size()), 64'(0));
    chk({tag, "_checksum"}, checksum, cs_exp());
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_done_after"}, 64'(done), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    exp_cs = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    chk("rst_cs", 64'(avm_chipselect), 64'(0));
    chk("rst_clken", 64'(avm_clken), 64'(0));
    chk("rst_addr", 64'(avm_address), 64'(0));
    chk("rst_checksum", checksum, 64'(0));
    reset_n = 1'b1;
    init_mem = 1'b0;
    @(posedge clk); #1;
    chk("clken_run", 64'(avm_clken), 64'(1));

    exp_fill(9'h010, 4, 64'hA5A5_A5A5_0000_FFFF, 8'hFF);
    issue(1'b1, 9'h000, 9'h010, 10'd4, 64'hA5A5_A5A5_0000_FFFF, 8'hFF);
    wait_done("fill4", 5, 1'b0);

    exp_copy(9'h000, 9'h100, 3);
    issue(1'b0, 9'h000, 9'h100, 10'd3, 64'h0, 8'h00);
    wait_done("copy3", 10, 1'b0);
    chk("copy3_mem102", mem[9'h102], 64'd3);

    exp_copy(9'h1FE, 9'h0F0, 4);
    issue(1'b0, 9'h1FE, 9'h0F0, 10'd4, 64'h0, 8'h00);
    wait_done("copy_wrap", 13, 1'b0);
    chk("copy_wrap_mem0f2", mem[9'h0F2], 64'd1);

    exp_copy(9'h100, 9'h101, 3);
    issue(1'b0, 9'h100, 9'h101, 10'd3, 64'h0, 8'h00);
    wait_done("copy_overlap", 10, 1'b0);
    chk("overlap_mem103", mem[9'h103], 64'd1);

    exp_cs = '0;
    issue(1'b0, 9'h020, 9'h030, 10'd0, 64'h0, 8'h00);
    chk("len0_busy", 64'(busy), 64'(1));
    wait_done("len0", 1, 1'b0);

    // Long fill, ignored second start, abort on the fifth write cycle.
    exp_fill(9'h040, 4, 64'h1234_5678_9ABC_DEF0, 8'hF0);
    issue(1'b1, 9'h000, 9'h040, 10'd100, 64'h1234_5678_9ABC_DEF0, 8'hF0);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_dst = 9'h1F0; cmd_len = 10'd3; cmd_fill_data = 64'hFFFF; cmd_fill_be = 8'h0F;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_abort = 1'b1;
    @(negedge clk);
    chk("abort_no_cs", 64'(avm_chipselect), 64'(0));
    chk("abort_no_done_yet", 64'(done), 64'(0));
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    @(negedge clk);
    chk("abort_done", 64'(done), 64'(1));
    chk("abort_aborted", 64'(aborted), 64'(1));
    chk("abort_wq_empty", 64'(wq.size()), 64'(0));
    chk("abort_checksum", checksum, cs_exp());
    @(posedge clk); #1;
    chk("abort_busy_after", 64'(busy), 64'(0));
    chk("abort_mem44", mem[9'h044], init_val(9'h044));

    @(posedge clk); #1;
    cmd_mode = 1'b1; cmd_dst = 9'h060; cmd_len = 10'd5; cmd_start = 1'b1; cmd_abort = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    chk("start_abort_idle_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("start_abort_idle_busy2", 64'(busy), 64'(0));

    exp_fill(9'h1FF, 2, 64'h0F, 8'h01);
    issue(1'b1, 9'h000, 9'h1FF, 10'd2, 64'h0F, 8'h01);
    wait_done("fill2_cs", 3, 1'b0);

    exp_fill(9'h1FF, 3, 64'h0F, 8'h01);
    issue(1'b1, 9'h000, 9'h1FF, 10'd3, 64'h0F, 8'h01);
    wait_done("fill3_cs", 4, 1'b0);

    // Reset in the middle of a fill: two writes land, then silence.
    exp_fill(9'h080, 2, 64'hCAFE, 8'hFF);
    issue(1'b1, 9'h000, 9'h080, 10'd50, 64'hCAFE, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cs", 64'(avm_chipselect), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_clken", 64'(avm_clken), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wq_empty", 64'(wq.size()), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
